// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - multi-digit BCD up/down counter with load, wrap/saturate and 7-segment decode
module bcd_counter_n #(
  parameter int NDIG     = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] bcd,
  output logic [7*NDIG-1:0] seg,
  output logic              tc
);

  logic [4*NDIG-1:0] bcd_step;
  logic [4*NDIG-1:0] load_clamped;
  logic              ripple;
  logic              at_max;
  logic              at_min;
  logic              limit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Carry/borrow ripples from digit 0 upward; it survives only through 9s (up) or 0s (down).
  always_comb begin
    bcd_step     = bcd;
    load_clamped = load_val;
    ripple       = 1'b1;
    at_max       = 1'b1;
    at_min       = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd9) at_max = 1'b0;
      if (bcd[4*i +: 4] != 4'd0) at_min = 1'b0;
      if (load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd0;
      if (ripple) begin
        if (up) begin
          if (bcd[4*i +: 4] == 4'd9) begin
            bcd_step[4*i +: 4] = 4'd0;
          end else begin
            bcd_step[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (bcd[4*i +: 4] == 4'd0) begin
            bcd_step[4*i +: 4] = 4'd9;
          end else begin
            bcd_step[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
    limit = up ? at_max : at_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      bcd <= load_clamped;
      tc  <= 1'b0;
    end else if (en) begin
      if (!(SATURATE && limit)) bcd <= bcd_step;
      tc <= limit;
    end else begin
      tc <= 1'b0;
    end
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_seg
    assign seg[7*g +: 7] = seg7(bcd[4*g +: 4]);
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - directed checks of bcd_counter_n in wrap, saturate and 2-digit builds
module tb_bcd_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
  logic [15:0] a_lv = '0, a_bcd;
  logic [27:0] a_seg;
  logic        a_tc;

  logic        s_rst = 1'b1, s_en = 1'b0, s_up = 1'b1, s_load = 1'b0;
  logic [15:0] s_lv = '0, s_bcd;
  logic [27:0] s_seg;
  logic        s_tc;

  logic        b_rst = 1'b1, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
  logic [7:0]  b_lv = '0, b_bcd;
  logic [13:0] b_seg;
  logic        b_tc;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_counter_n #(.NDIG(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_lv), .bcd(a_bcd), .seg(a_seg), .tc(a_tc));

  bcd_counter_n #(.NDIG(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .up(s_up), .load(s_load),
    .load_val(s_lv), .bcd(s_bcd), .seg(s_seg), .tc(s_tc));

  bcd_counter_n #(.NDIG(2), .SATURATE(1'b0)) u_two (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_lv), .bcd(b_bcd), .seg(b_seg), .tc(b_tc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // wrap build: reset, count 12, wrap up, wrap down, borrow chain, priority
    tick(); tick();
    check("rst_bcd", a_bcd, 32'h0);
    check("rst_tc", a_tc, 32'h0);
    check("rst_seg", a_seg, {4{7'h3F}});
    a_rst = 1'b0; a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("cnt12_tc", a_tc, 32'h0);
    end
    check("cnt12_bcd", a_bcd, 32'h0012);
    check("cnt12_seg0", a_seg[6:0], 32'h5B);
    check("cnt12_seg1", a_seg[13:7], 32'h06);

    a_en = 1'b0; tick();
    check("hold_bcd", a_bcd, 32'h0012);
    check("hold_tc", a_tc, 32'h0);

    a_load = 1'b1; a_lv = 16'h9998; tick();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    check("ldup_bcd", a_bcd, 32'h9998);
    tick(); check("wup1_bcd", a_bcd, 32'h9999); check("wup1_tc", a_tc, 32'h0);
    tick(); check("wup2_bcd", a_bcd, 32'h0000); check("wup2_tc", a_tc, 32'h1);
    tick(); check("wup3_bcd", a_bcd, 32'h0001); check("wup3_tc", a_tc, 32'h0);

    a_en = 1'b0; a_load = 1'b1; a_lv = 16'h0001; tick();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
    tick(); check("wdn1_bcd", a_bcd, 32'h0000); check("wdn1_tc", a_tc, 32'h0);
    tick(); check("wdn2_bcd", a_bcd, 32'h9999); check("wdn2_tc", a_tc, 32'h1);
    check("wdn2_seg", a_seg, {4{7'h6F}});
    tick(); check("wdn3_bcd", a_bcd, 32'h9998); check("wdn3_tc", a_tc, 32'h0);

    a_load = 1'b1; a_lv = 16'h1000; tick();
    a_load = 1'b0;
    tick(); check("borrow_bcd", a_bcd, 32'h0999); check("borrow_tc", a_tc, 32'h0);

    a_up = 1'b1; tick();
    check("dirchg_bcd", a_bcd, 32'h1000);

    a_load = 1'b1; a_en = 1'b1; a_lv = 16'h3A7F; tick();
    check("clamp_bcd", a_bcd, 32'h3070);
    check("clamp_tc", a_tc, 32'h0);
    check("clamp_seg", a_seg, {7'h4F, 7'h3F, 7'h07, 7'h3F});
    a_rst = 1'b1; tick();
    check("rstld_bcd", a_bcd, 32'h0000);
    check("rstld_tc", a_tc, 32'h0);
    a_rst = 1'b0; a_load = 1'b0; tick();
    check("resume_bcd", a_bcd, 32'h0001);

    // saturating build
    s_rst = 1'b0; s_load = 1'b1; s_lv = 16'h9998; tick();
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
    tick(); check("sat1_bcd", s_bcd, 32'h9999); check("sat1_tc", s_tc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("sathold_bcd", s_bcd, 32'h9999); check("sathold_tc", s_tc, 32'h1);
    end
    s_up = 1'b0;
    tick(); check("satdn_bcd", s_bcd, 32'h9998); check("satdn_tc", s_tc, 32'h0);
    s_load = 1'b1; s_lv = 16'h0000; tick();
    s_load = 1'b0;
    tick(); check("satmin_bcd", s_bcd, 32'h0000); check("satmin_tc", s_tc, 32'h1);
    s_en = 1'b0;
    tick(); check("satidle_tc", s_tc, 32'h0);

    // two-digit build
    b_rst = 1'b0; b_load = 1'b1; b_lv = 8'h99; tick();
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    tick();
    check("two_bcd", b_bcd, 32'h00);
    check("two_tc", b_tc, 32'h1);
    check("two_seg", b_seg, {7'h3F, 7'h3F});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
